// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate L1 data cache with a 128-bit block memory port.
// Hits complete combinationally; misses stall through optional writeback then refill.
module dcache_direct_mapped #(
    parameter int unsigned NUM_SETS = 8,
    parameter int unsigned WORDS    = 4
) (
    input  logic         i_clk,
    input  logic         i_proc_reset,
    input  logic         i_proc_read,
    input  logic         i_proc_write,
    input  logic [29:0]  i_proc_addr,
    input  logic [31:0]  i_proc_wdata,
    output logic [31:0]  o_proc_rdata,
    output logic         o_proc_stall,
    output logic         o_mem_read,
    output logic         o_mem_write,
    output logic [27:0]  o_mem_addr,
    output logic [127:0] o_mem_wdata,
    input  logic [127:0] i_mem_rdata,
    input  logic         i_mem_ready
);

    localparam int unsigned IDX_W  = $clog2(NUM_SETS);
    localparam int unsigned TAG_W  = 28 - IDX_W;
    localparam int unsigned LINE_W = WORDS * 32;

    localparam logic [1:0] StIdle      = 2'd0;
    localparam logic [1:0] StWriteback = 2'd1;
    localparam logic [1:0] StAllocate  = 2'd2;

    logic [1:0]          r_state;
    logic [NUM_SETS-1:0] r_valid;
    logic [NUM_SETS-1:0] r_dirty;
    logic [TAG_W-1:0]    r_tag  [NUM_SETS];
    logic [LINE_W-1:0]   r_data [NUM_SETS];
    logic [IDX_W-1:0]    r_miss_idx;
    logic [TAG_W-1:0]    r_miss_tag;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [27:0]         r_mem_addr;
    logic [LINE_W-1:0]   r_mem_wdata;

    logic [1:0]        w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_req;
    logic              w_hit;
    logic              w_wr_hit;
    logic [LINE_W-1:0] w_line;
    logic [LINE_W-1:0] w_merged;

    assign w_off    = i_proc_addr[1:0];
    assign w_idx    = i_proc_addr[IDX_W+1:2];
    assign w_tag    = i_proc_addr[29:IDX_W+2];
    assign w_req    = i_proc_read | i_proc_write;
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_line   = r_data[w_idx];
    assign w_wr_hit = !i_proc_reset && (r_state == StIdle) && i_proc_write && w_hit;

    always_comb begin
        w_merged = w_line;
        w_merged[{w_off, 5'd0} +: 32] = i_proc_wdata;
    end

    // A simultaneous read+write is a write, so rdata stays at zero for it.
    always_comb begin
        o_proc_stall = 1'b0;
        o_proc_rdata = 32'd0;
        if (!i_proc_reset) begin
            if (r_state != StIdle) begin
                o_proc_stall = 1'b1;
            end else if (w_req) begin
                if (!w_hit) begin
                    o_proc_stall = 1'b1;
                end else if (!i_proc_write) begin
                    o_proc_rdata = w_line[{w_off, 5'd0} +: 32];
                end
            end
        end
    end

    assign o_mem_read  = r_mem_read;
    assign o_mem_write = r_mem_write;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

    // Memory-side outputs are registered on each transition so they never follow proc inputs.
    always_ff @(posedge i_clk or posedge i_proc_reset) begin
        if (i_proc_reset) begin
            r_state     <= StIdle;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_miss_idx  <= '0;
            r_miss_tag  <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_req) begin
                        if (w_hit) begin
                            if (i_proc_write) begin
                                r_dirty[w_idx] <= 1'b1;
                            end
                        end else begin
                            r_miss_idx <= w_idx;
                            r_miss_tag <= w_tag;
                            if (r_valid[w_idx] && r_dirty[w_idx]) begin
                                r_state     <= StWriteback;
                                r_mem_write <= 1'b1;
                                r_mem_addr  <= {r_tag[w_idx], w_idx};
                                r_mem_wdata <= w_line;
                            end else begin
                                r_state    <= StAllocate;
                                r_mem_read <= 1'b1;
                                r_mem_addr <= {w_tag, w_idx};
                            end
                        end
                    end
                end
                StWriteback: begin
                    if (i_mem_ready) begin
                        r_state             <= StAllocate;
                        r_dirty[r_miss_idx] <= 1'b0;
                        r_mem_write         <= 1'b0;
                        r_mem_wdata         <= '0;
                        r_mem_read          <= 1'b1;
                        r_mem_addr          <= {r_miss_tag, r_miss_idx};
                    end
                end
                StAllocate: begin
                    if (i_mem_ready) begin
                        r_state             <= StIdle;
                        r_valid[r_miss_idx] <= 1'b1;
                        r_dirty[r_miss_idx] <= 1'b0;
                        r_mem_read          <= 1'b0;
                        r_mem_addr          <= '0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Tag and data arrays need no reset; valid bits gate every use.
    always_ff @(posedge i_clk) begin
        if (w_wr_hit) begin
            r_data[w_idx] <= w_merged;
        end else if (!i_proc_reset && (r_state == StAllocate) && i_mem_ready) begin
            r_data[r_miss_idx] <= i_mem_rdata;
            r_tag[r_miss_idx]  <= r_miss_tag;
        end
    end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Directed self-checking bench for dcache_direct_mapped.
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_dcache_direct_mapped;

    logic         clk;
    logic         rst;
    logic         rd;
    logic         wr;
    logic [29:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         stall;
    logic         mem_rd;
    logic         mem_wr;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int checks;
    int failures;

    dcache_direct_mapped #(.NUM_SETS(8), .WORDS(4)) dut (
        .i_clk        (clk),
        .i_proc_reset (rst),
        .i_proc_read  (rd),
        .i_proc_write (wr),
        .i_proc_addr  (addr),
        .i_proc_wdata (wdata),
        .o_proc_rdata (rdata),
        .o_proc_stall (stall),
        .o_mem_read   (mem_rd),
        .o_mem_write  (mem_wr),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .i_mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse mem_ready for one cycle with the given refill data.
    task automatic mem_pulse(input logic [127:0] data);
        mem_rdata = data;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_proc: stall=%b rdata=%h want 0/0", stall, rdata);
        end
        checks++;
        if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== 28'd0 || mem_wdata !== 128'd0) begin
            failures++;
            $display("FAIL reset_mem: rd=%b wr=%b addr=%h wdata=%h want all 0",
                     mem_rd, mem_wr, mem_addr, mem_wdata);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_read_miss();
        rd = 1'b1;
        addr = 30'h4;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || mem_rd !== 1'b0) begin
            failures++;
            $display("FAIL miss_stall: stall=%b mem_read=%b want 1/0", stall, mem_rd);
        end
        step();
        @(negedge clk);
        checks++;
        if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 28'h1 || stall !== 1'b1) begin
            failures++;
            $display("FAIL alloc_req: rd=%b wr=%b addr=%h stall=%b want 1/0/1/1",
                     mem_rd, mem_wr, mem_addr, stall);
        end
        repeat (4) step();
        mem_pulse({32'hD, 32'hC, 32'hB, 32'hA});
        @(negedge clk);
        checks++;
        if (rdata !== 32'hA || stall !== 1'b0 || mem_rd !== 1'b0) begin
            failures++;
            $display("FAIL refill_read: rdata=%h stall=%b mem_read=%b want A/0/0",
                     rdata, stall, mem_rd);
        end
        step();
    endtask

    task automatic test_read_hit();
        addr = 30'h5;
        @(negedge clk);
        checks++;
        if (rdata !== 32'hB || stall !== 1'b0 || mem_rd !== 1'b0) begin
            failures++;
            $display("FAIL read_hit: rdata=%h stall=%b mem_read=%b want B/0/0", rdata, stall, mem_rd);
        end
        step();
    endtask

    task automatic test_write_hit();
        rd = 1'b0;
        wr = 1'b1;
        addr = 30'h6;
        wdata = 32'h1234;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
            failures++;
            $display("FAIL write_hit_stall: stall=%b rd=%b wr=%b want 0/0/0", stall, mem_rd, mem_wr);
        end
        step();
        wr = 1'b0;
        rd = 1'b1;
        @(negedge clk);
        checks++;
        if (rdata !== 32'h1234) begin
            failures++;
            $display("FAIL write_readback: rdata=%h want 1234", rdata);
        end
        step();
    endtask

    task automatic test_dirty_evict();
        addr = 30'h24;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || mem_wr !== 1'b0) begin
            failures++;
            $display("FAIL evict_stall: stall=%b mem_write=%b want 1/0", stall, mem_wr);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            checks++;
            if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 28'h1 ||
                mem_wdata !== {32'hD, 32'h1234, 32'hB, 32'hA} || stall !== 1'b1) begin
                failures++;
                $display("FAIL writeback_%0d: wr=%b rd=%b addr=%h wdata=%h stall=%b want 1/0/1/%h/1",
                         i, mem_wr, mem_rd, mem_addr, mem_wdata, stall,
                         {32'hD, 32'h1234, 32'hB, 32'hA});
            end
        end
        step();
        mem_pulse(128'h0);
        @(negedge clk);
        checks++;
        if (mem_wr !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 28'h9 || stall !== 1'b1) begin
            failures++;
            $display("FAIL evict_alloc: wr=%b rd=%b addr=%h stall=%b want 0/1/9/1",
                     mem_wr, mem_rd, mem_addr, stall);
        end
        step();
        mem_pulse({32'h4, 32'h3, 32'h2, 32'h1});
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || rdata !== 32'h1) begin
            failures++;
            $display("FAIL evict_refill: stall=%b rdata=%h want 0/1", stall, rdata);
        end
        step();
    endtask

    task automatic test_ready_in_idle();
        rd = 1'b0;
        mem_pulse({32'hFF, 32'hFF, 32'hFF, 32'hFF});
        @(negedge clk);
        checks++;
        if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL idle_ready: rd=%b wr=%b stall=%b want 0/0/0", mem_rd, mem_wr, stall);
        end
        step();
        rd = 1'b1;
        addr = 30'h24;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || rdata !== 32'h1) begin
            failures++;
            $display("FAIL idle_ready_line: stall=%b rdata=%h want 0/1", stall, rdata);
        end
        step();
    endtask

    task automatic test_index_wrap();
        addr = 30'h1C;
        step();
        @(negedge clk);
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 28'h7) begin
            failures++;
            $display("FAIL wrap_alloc: rd=%b addr=%h want 1/7", mem_rd, mem_addr);
        end
        mem_pulse({32'h73, 32'h72, 32'h71, 32'h70});
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || rdata !== 32'h70) begin
            failures++;
            $display("FAIL wrap_read: stall=%b rdata=%h want 0/70", stall, rdata);
        end
        step();
        addr = 30'h25;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || rdata !== 32'h2) begin
            failures++;
            $display("FAIL other_set_intact: stall=%b rdata=%h want 0/2", stall, rdata);
        end
        step();
    endtask

    task automatic test_reset_mid_alloc();
        addr = 30'h4;
        step();
        @(negedge clk);
        checks++;
        if (mem_rd !== 1'b1 || stall !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_alloc: rd=%b stall=%b want 1/1", mem_rd, stall);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_rd !== 1'b0 || stall !== 1'b0 || mem_addr !== 28'd0 || rdata !== 32'd0) begin
            failures++;
            $display("FAIL async_reset: rd=%b stall=%b addr=%h rdata=%h want 0/0/0/0",
                     mem_rd, stall, mem_addr, rdata);
        end
        step();
        rst = 1'b0;
        addr = 30'h24;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_miss: stall=%b want 1", stall);
        end
        step();
        mem_pulse({32'h58, 32'h57, 32'h56, 32'h55});
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || rdata !== 32'h55) begin
            failures++;
            $display("FAIL post_reset_refill: stall=%b rdata=%h want 0/55", stall, rdata);
        end
        step();
    endtask

    task automatic test_read_write_both();
        rd = 1'b1;
        wr = 1'b1;
        addr = 30'h7;
        wdata = 32'hCAFE;
        step();
        mem_pulse({32'hD, 32'hC, 32'hB, 32'hA});
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || mem_rd !== 1'b0) begin
            failures++;
            $display("FAIL rw_hit_stall: stall=%b mem_read=%b want 0/0", stall, mem_rd);
        end
        step();
        wr = 1'b0;
        @(negedge clk);
        checks++;
        if (rdata !== 32'hCAFE) begin
            failures++;
            $display("FAIL rw_readback: rdata=%h want CAFE", rdata);
        end
        step();
        addr = 30'h24;
        step();
        @(negedge clk);
        checks++;
        if (mem_wr !== 1'b1 || mem_addr !== 28'h1 ||
            mem_wdata !== {32'hCAFE, 32'hC, 32'hB, 32'hA}) begin
            failures++;
            $display("FAIL rw_dirty_wb: wr=%b addr=%h wdata=%h want 1/1/%h",
                     mem_wr, mem_addr, mem_wdata, {32'hCAFE, 32'hC, 32'hB, 32'hA});
        end
        mem_pulse(128'h0);
        mem_pulse({32'h4, 32'h3, 32'h2, 32'h1});
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || rdata !== 32'h1) begin
            failures++;
            $display("FAIL rw_final_read: stall=%b rdata=%h want 0/1", stall, rdata);
        end
        step();
        rd = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        rd = 1'b0;
        wr = 1'b0;
        addr = '0;
        wdata = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        #1;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_dirty_evict();
        test_ready_in_idle();
        test_index_wrap();
        test_reset_mid_alloc();
        test_read_write_both();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
